// File: rtl/fpmult_norm_round_stage.sv
// Normalize / round-to-nearest-even / pack stage that follows the 24x24 mantissa multiplier.
// Two registered stages (normalize, round+pack) with a valid/ready handshake and no skid buffer.
module fpmult_norm_round_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*(MAN_W+1)-1:0]       Mp,
  input  logic                         Sp,
  input  logic [EXP_W+1:0]             Ep,
  input  logic                         in_nan,
  input  logic                         in_inf,
  input  logic                         in_zero,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_W+MAN_W:0]         Z,
  output logic                         out_ovf,
  output logic                         out_unf,
  output logic                         out_inexact
);

  localparam int PW = 2 * (MAN_W + 1);
  // One bit wider than Ep so that Ep+1 and the rounding carry can never wrap.
  localparam int EW = EXP_W + 3;

  // With BIAS = 2^(EXP_W-1)-1, the all-ones exponent 2^EXP_W-1 equals 2*BIAS+1.
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 * BIAS + 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  typedef struct packed {
    logic                   sign;
    logic [MAN_W-1:0]       frac;
    logic                   g;
    logic                   st;
    logic signed [EW-1:0]   exp;
    logic                   nan;
    logic                   inf;
    logic                   zero;
  } norm_t;

  logic  s1_valid;
  norm_t s1_d;
  norm_t s1_q;
  logic  s1_adv;
  logic  s2_adv;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // ---------------------------------------------------------------------------
  // S1: normalize. A product of two normalized mantissas lies in [1,4), so the
  // leading one sits in one of the top two bits.
  // ---------------------------------------------------------------------------
  logic                 prod_msb;
  logic signed [EW-1:0] ep_ext;

  assign prod_msb = Mp[PW-1];
  assign ep_ext   = $signed({Ep[EXP_W+1], Ep});

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = Sp;
    s1_d.nan  = in_nan;
    s1_d.inf  = in_inf;
    s1_d.zero = in_zero;
    if (prod_msb) begin
      s1_d.frac = Mp[PW-2:MAN_W+1];
      s1_d.g    = Mp[MAN_W];
      s1_d.st   = |Mp[MAN_W-1:0];
      s1_d.exp  = ep_ext + EW'(1);
    end else begin
      s1_d.frac = Mp[PW-3:MAN_W];
      s1_d.g    = Mp[MAN_W-1];
      s1_d.st   = |Mp[MAN_W-2:0];
      s1_d.exp  = ep_ext;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: the S1 payload is qualified by s1_valid, so it carries no reset;
  // only the control bits and the visible outputs are cleared.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_q <= s1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: round to nearest even, range check, special-case override, pack.
  // ---------------------------------------------------------------------------
  logic                   round_up;
  logic [MAN_W:0]         round_sum;
  logic                   round_carry;
  logic [MAN_W-1:0]       round_frac;
  logic signed [EW-1:0]   round_exp;

  assign round_up    = s1_q.g && (s1_q.st || s1_q.frac[0]);
  assign round_sum   = {1'b0, s1_q.frac} + {{MAN_W{1'b0}}, round_up};
  assign round_carry = round_sum[MAN_W];
  // A carry out leaves the low bits at zero, which is the renormalized fraction.
  assign round_frac  = round_sum[MAN_W-1:0];
  assign round_exp   = s1_q.exp + $signed({{(EW-1){1'b0}}, round_carry});

  logic [EXP_W+MAN_W:0] z_next;
  logic                 ovf_next;
  logic                 unf_next;
  logic                 inexact_next;

  always_comb begin
    z_next       = {s1_q.sign, round_exp[EXP_W-1:0], round_frac};
    ovf_next     = 1'b0;
    unf_next     = 1'b0;
    inexact_next = s1_q.g | s1_q.st;

    if (round_exp >= EXP_MAX) begin
      z_next       = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_next     = 1'b1;
      inexact_next = 1'b1;
    end else if (round_exp <= EXP_ZERO) begin
      z_next       = {s1_q.sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      unf_next     = 1'b1;
      inexact_next = 1'b1;
    end

    // Special operands win over the arithmetic result; nan > inf > zero.
    if (s1_q.nan) begin
      z_next       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      ovf_next     = 1'b0;
      unf_next     = 1'b0;
      inexact_next = 1'b0;
    end else if (s1_q.inf) begin
      z_next       = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_next     = 1'b0;
      unf_next     = 1'b0;
      inexact_next = 1'b0;
    end else if (s1_q.zero) begin
      z_next       = {s1_q.sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      ovf_next     = 1'b0;
      unf_next     = 1'b0;
      inexact_next = 1'b0;
    end
  end

  // Result registers only load on a real beat, so they hold through stalls and bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      Z           <= '0;
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Z           <= z_next;
        out_ovf     <= ovf_next;
        out_unf     <= unf_next;
        out_inexact <= inexact_next;
      end
    end
  end

endmodule

// File: tb/tb_fpmult_norm_round_stage.sv
// Self-checking bench for fpmult_norm_round_stage: directed spec vectors, backpressure,
// mid-flight reset and randomized products scored against an arithmetic rounding model.
module tb_fpmult_norm_round_stage;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int PW    = 48;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [PW-1:0]   Mp = '0;
  logic            Sp = 1'b0;
  logic [9:0]      Ep = '0;
  logic            in_nan = 1'b0;
  logic            in_inf = 1'b0;
  logic            in_zero = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     Z;
  logic            out_ovf;
  logic            out_unf;
  logic            out_inexact;

  fpmult_norm_round_stage #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(127)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Mp(Mp), .Sp(Sp), .Ep(Ep),
    .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .Z(Z), .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          delivered = 0;
  logic [34:0] exp_q[$];
  logic [34:0] exp_beat;
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out = '0;
  logic        rand_on = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Exact rounding of the real product: keep 24 significant bits, compare the
  // discarded remainder against one half ulp, ties to even.
  function automatic logic [34:0] ref_model(input logic [47:0] mp, input logic sp, input int ep,
                                             input logic nan, input logic inf, input logic zero);
    longint unsigned m, kept, rem, half;
    int   shift, e;
    logic [31:0] z;
    logic ovf, unf, inx;
    if (nan)  return {32'h7FC00000, 3'b000};
    if (inf)  return {sp, 8'hFF, 23'h0, 3'b000};
    if (zero) return {sp, 31'h0, 3'b000};
    m     = {16'h0, mp};
    shift = mp[47] ? 24 : 23;
    kept  = m >> shift;
    rem   = m - (kept << shift);
    half  = 64'd1 << (shift - 1);
    e     = ep + shift - 23;
    if (rem > half || (rem == half && (kept & 64'd1) == 64'd1)) kept = kept + 1;
    if (kept >= (64'd1 << 24)) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    ovf = 1'b0;
    unf = 1'b0;
    inx = (rem != 0);
    if (e >= 255) begin
      z = {sp, 8'hFF, 23'h0}; ovf = 1'b1; inx = 1'b1;
    end else if (e <= 0) begin
      z = {sp, 31'h0};        unf = 1'b1; inx = 1'b1;
    end else begin
      z = {sp, 8'(e), 23'(kept)};
    end
    return {z, ovf, unf, inx};
  endfunction

  // Offer one beat (called just after a rising edge) and hold it until accepted.
  task automatic send(input logic [47:0] mp, input logic sp, input int ep,
                      input logic nan, input logic inf, input logic zero, input logic [34:0] want);
    int budget = 0;
    in_valid = 1'b1; Mp = mp; Sp = sp; Ep = 10'(ep);
    in_nan = nan; in_inf = inf; in_zero = zero;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 200) begin
        check("accept_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    exp_q.push_back(want);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [47:0] mp, input logic sp, input int ep,
                            input logic nan, input logic inf, input logic zero);
    send(mp, sp, ep, nan, inf, zero, ref_model(mp, sp, ep, nan, inf, zero));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: scores delivered beats and checks hold behaviour during stalls.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'({Z, out_ovf, out_unf, out_inexact}), 64'(prev_out));
      end
      if (out_valid && out_ready) begin
        delivered++;
        check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          check("z", 64'(Z), 64'(exp_beat[34:3]));
          check("flags", 64'({out_ovf, out_unf, out_inexact}), 64'(exp_beat[2:0]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {Z, out_ovf, out_unf, out_inexact};
    end
  end

  int base;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_z", 64'(Z), 64'd0);
    check("rst_flags", 64'({out_ovf, out_unf, out_inexact}), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Latency and directed vectors
    out_ready = 1'b1;
    send(48'h900000000000, 1'b0, 127, 1'b0, 1'b0, 1'b0, {32'h40100000, 3'b000});
    check("lat_s1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_s2", 64'(out_valid), 64'd1);
    send(48'h7FFFFFC00000, 1'b0, 127, 1'b0, 1'b0, 1'b0, {32'h40000000, 3'b001});
    send(48'h400000400000, 1'b0, 127, 1'b0, 1'b0, 1'b0, {32'h3F800000, 3'b001});
    send(48'h800000000000, 1'b1, 254, 1'b0, 1'b0, 1'b0, {32'hFF800000, 3'b101});
    send(48'h400000000000, 1'b0,   0, 1'b0, 1'b0, 1'b0, {32'h00000000, 3'b011});
    send(48'h800000000000, 1'b1, 254, 1'b1, 1'b1, 1'b0, {32'h7FC00000, 3'b000});
    send(48'h900000000000, 1'b1, 127, 1'b0, 1'b1, 1'b1, {32'hFF800000, 3'b000});
    send(48'h900000000000, 1'b1, 300, 1'b0, 1'b0, 1'b1, {32'h80000000, 3'b000});
    wait_drain(50);

    // Backpressure: two beats fill the pipe, the third is refused
    out_ready = 1'b0;
    send_model(48'h900000000000, 1'b0, 100, 1'b0, 1'b0, 1'b0);
    send_model(48'h7FFFFFC00000, 1'b1, 130, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_model(48'h400000400000, 1'b0, 5, 1'b0, 1'b0, 1'b0);
    wait_drain(50);

    // Reset with two beats in flight
    send_model(48'h900000000000, 1'b0, 50, 1'b0, 1'b0, 1'b0);
    send_model(48'hC00000000000, 1'b1, 60, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    base = delivered;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale", 64'(delivered - base), 64'd0);

    // Randomized products with random backpressure and input gaps
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          logic [23:0] a, b;
          logic [47:0] mp;
          int ep, r;
          a  = {1'b1, 23'($urandom)};
          b  = {1'b1, 23'($urandom)};
          mp = {24'h0, a} * {24'h0, b};
          if ($urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 6);
            ep = (r == 0) ? -1 : (r == 1) ? 0 : (r == 2) ? 1 : (r == 3) ? 126 :
                 (r == 4) ? 253 : (r == 5) ? 254 : 255;
          end else begin
            ep = int'($urandom_range(0, 330)) - 40;
          end
          r = $urandom_range(0, 19);
          send_model(mp, 1'($urandom), ep, r == 0, r <= 1, r == 0 || r == 2);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        rand_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    wait_drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
